monty_corr_sched: RTL

- Round-robin scheduler that shares one final-correction pipeline among N Montgomery-multiplier requesters.
- Each request carries a reduced-but-unsubtracted value C (LOGC bits); the block issues it to the shared unit and tracks it with a LAT-deep tag pipeline.
- Returns each corrected result T to its requester id.
- Owns the modulus-high register (qH) and sequences safe qH updates by draining the pipeline first.

---
 rtl/monty_corr_sched_if.sv | 33 +++
 rtl/monty_corr_sched.sv | 95 +++++++++
 2 files changed

// File: rtl/monty_corr_sched_if.sv
// Request, correction-unit, result and config signals of the shared Montgomery
// final-correction scheduler. The scheduler takes the slave side.
interface monty_corr_sched_if #(
  parameter int N     = 4,
  parameter int LOGQ  = 64,
  parameter int LOGQH = 17,
  parameter int LOGC  = LOGQ + 1,
  parameter int IDW   = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]      req_valid;
  logic [N*LOGC-1:0] req_C;
  logic [N-1:0]      req_ready;
  logic [LOGC-1:0]   cu_C;
  logic [LOGQH-1:0]  cu_qH;
  logic [LOGQ-1:0]   cu_T;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [LOGQ-1:0]   res_T;
  logic              cfg_we;
  logic [LOGQH-1:0]  cfg_qH;
  logic              cfg_busy;
  logic              cfg_done;

  modport slave (
    input  req_valid, req_C, cu_T, cfg_we, cfg_qH,
    output req_ready, cu_C, cu_qH, res_valid, res_id, res_T, cfg_busy, cfg_done
  );

  modport master (
    output req_valid, req_C, cu_T, cfg_we, cfg_qH,
    input  req_ready, cu_C, cu_qH, res_valid, res_id, res_T, cfg_busy, cfg_done
  );
endinterface

// File: rtl/monty_corr_sched.sv
// Round-robin sharing of one fixed-latency correction unit among N requesters,
// with a tag pipe routing results back and a drain-then-load qH update.
module monty_corr_sched #(
  parameter int               N        = 4,
  parameter int               LOGQ     = 64,
  parameter int               LOGQH    = 17,
  parameter int               LOGC     = LOGQ + 1,
  parameter int               LAT      = 3,
  parameter logic [LOGQH-1:0] QH_RESET = '0,
  parameter int               IDW      = (N > 1) ? $clog2(N) : 1
) (
  input logic clk,
  input logic rst,
  monty_corr_sched_if.slave bus
);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]              state, state_nxt;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          grant_id;
  logic                    issue;
  logic [LOGQH-1:0]        qh_r, qh_pend;
  logic [LAT-1:0]          tag_v;
  logic [LAT-1:0][IDW-1:0] tag_id;
  logic                    inflight_nxt;

  // Gating with rst keeps grants off while reset is asserted, not only after it.
  always_comb begin
    int idx;
    idx      = 0;
    issue    = 1'b0;
    grant_id = '0;
    if (state == ST_RUN && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!issue && bus.req_valid[idx]) begin
          issue    = 1'b1;
          grant_id = IDW'(idx);
        end
      end
    end
  end

  // Pipe occupancy after this edge: a result leaving now does not hold up a load.
  always_comb begin
    inflight_nxt = issue;
    for (int i = 0; i < LAT - 1; i++) inflight_nxt = inflight_nxt | tag_v[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.cfg_we) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!inflight_nxt) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      ptr     <= '0;
      tag_v   <= '0;
      tag_id  <= '0;
      qh_r    <= QH_RESET;
      qh_pend <= '0;
    end else begin
      state     <= state_nxt;
      tag_v[0]  <= issue;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (issue) begin
        if (grant_id == IDW'(N - 1)) ptr <= '0;
        else                         ptr <= grant_id + IDW'(1);
      end
      if (state == ST_RUN && bus.cfg_we) qh_pend <= bus.cfg_qH;
      if (state == ST_LOAD)              qh_r    <= qh_pend;
    end
  end

  assign bus.req_ready = issue ? (N'(1) << grant_id) : '0;
  assign bus.cu_C      = issue ? bus.req_C[int'(grant_id)*LOGC +: LOGC] : '0;
  assign bus.cu_qH     = qh_r;
  assign bus.res_valid = tag_v[LAT-1];
  assign bus.res_id    = tag_id[LAT-1];
  assign bus.res_T     = bus.cu_T;
  assign bus.cfg_busy  = (state != ST_RUN);
  assign bus.cfg_done  = (state == ST_LOAD);
endmodule
